// File: rtl/expr_pkg.sv
// rtl/expr_pkg.sv - shared state, character-class and error-code constants for the expression checker
package expr_pkg;

    typedef enum logic [1:0] {
        S_EXP = 2'd0,
        S_NUM = 2'd1,
        S_CLS = 2'd2,
        S_ERR = 2'd3
    } state_t;

    localparam logic [2:0] DIG = 3'd0;
    localparam logic [2:0] OP  = 3'd1;
    localparam logic [2:0] LP  = 3'd2;
    localparam logic [2:0] RP  = 3'd3;
    localparam logic [2:0] BAD = 3'd4;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_SYN  = 2'd1;
    localparam logic [1:0] ERR_OVF  = 2'd2;
    localparam logic [1:0] ERR_UNF  = 2'd3;

endpackage

// File: rtl/expr_char_class.sv
// rtl/expr_char_class.sv - combinational ASCII to character-class decoder
module expr_char_class
    import expr_pkg::*;
(
    input  logic [7:0] ch,
    output logic [2:0] cls
);

    always_comb begin
        cls = BAD;
        if (ch >= 8'h30 && ch <= 8'h39) begin
            cls = DIG;
        end else begin
            case (ch)
                8'h2B, 8'h2D, 8'h2A, 8'h2F: cls = OP;
                8'h28:                      cls = LP;
                8'h29:                      cls = RP;
                default:                    cls = BAD;
            endcase
        end
    end

endmodule

// File: rtl/expr_nest_checker.sv
// rtl/expr_nest_checker.sv - streaming syntax checker for parenthesised arithmetic expressions
module expr_nest_checker
    import expr_pkg::*;
#(
    parameter int MAX_DEPTH   = 8,
    parameter int MULTI_DIGIT = 1,
    parameter int LEN_W       = 8,
    localparam int DEPTH_W    = $clog2(MAX_DEPTH + 1)
) (
    input  logic               clk,
    input  logic               clr,
    input  logic [7:0]         in,
    input  logic               in_valid,
    output logic               out,
    output logic               err,
    output logic [1:0]         err_code,
    output logic [DEPTH_W-1:0] depth,
    output logic [LEN_W-1:0]   len
);

    localparam logic [DEPTH_W-1:0] DEPTH_MAX = DEPTH_W'(MAX_DEPTH);
    localparam logic [DEPTH_W-1:0] DEPTH_ONE = DEPTH_W'(1);

    state_t             state, state_n;
    logic [DEPTH_W-1:0] depth_r, depth_n;
    logic [1:0]         code_r, code_n;
    logic [LEN_W-1:0]   len_r;
    logic [2:0]         cls;

    expr_char_class u_class (
        .ch  (in),
        .cls (cls)
    );

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state   <= S_EXP;
            depth_r <= '0;
            code_r  <= ERR_NONE;
            len_r   <= '0;
        end else if (in_valid) begin
            state   <= state_n;
            depth_r <= depth_n;
            code_r  <= code_n;
            if (len_r != {LEN_W{1'b1}}) begin
                len_r <= len_r + LEN_W'(1);
            end
        end
    end

    // Overflow/underflow are trapped before the arithmetic, so depth never wraps.
    always_comb begin
        state_n = state;
        depth_n = depth_r;
        code_n  = code_r;
        case (state)
            S_EXP: begin
                case (cls)
                    DIG: state_n = S_NUM;
                    LP: begin
                        if (depth_r == DEPTH_MAX) begin
                            state_n = S_ERR;
                            code_n  = ERR_OVF;
                        end else begin
                            depth_n = depth_r + DEPTH_ONE;
                        end
                    end
                    default: begin
                        state_n = S_ERR;
                        code_n  = ERR_SYN;
                    end
                endcase
            end
            S_NUM, S_CLS: begin
                case (cls)
                    OP: state_n = S_EXP;
                    RP: begin
                        if (depth_r == '0) begin
                            state_n = S_ERR;
                            code_n  = ERR_UNF;
                        end else begin
                            depth_n = depth_r - DEPTH_ONE;
                            state_n = S_CLS;
                        end
                    end
                    DIG: begin
                        if (state == S_NUM && MULTI_DIGIT != 0) begin
                            state_n = S_NUM;
                        end else begin
                            state_n = S_ERR;
                            code_n  = ERR_SYN;
                        end
                    end
                    default: begin
                        state_n = S_ERR;
                        code_n  = ERR_SYN;
                    end
                endcase
            end
            default: begin
                state_n = S_ERR;
            end
        endcase
    end

    assign out      = (state == S_NUM || state == S_CLS) && (depth_r == '0);
    assign err      = (state == S_ERR);
    assign err_code = code_r;
    assign depth    = depth_r;
    assign len      = len_r;

endmodule

// File: tb/tb_expr_nest_checker.sv
// tb/tb_expr_nest_checker.sv - self-checking bench for expr_nest_checker
module tb_expr_nest_checker;

    logic       clk = 1'b0;
    logic       clr;
    logic [7:0] in;
    logic       in_valid;

    logic       out_a, err_a;
    logic [1:0] code_a;
    logic [3:0] depth_a;
    logic [7:0] len_a;

    logic       out_b, err_b;
    logic [1:0] code_b;
    logic [1:0] depth_b;
    logic [2:0] len_b;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [7:0] hist[$];

    always #5 clk = ~clk;

    expr_nest_checker #(.MAX_DEPTH(8), .MULTI_DIGIT(1), .LEN_W(8)) dut_a (
        .clk(clk), .clr(clr), .in(in), .in_valid(in_valid),
        .out(out_a), .err(err_a), .err_code(code_a), .depth(depth_a), .len(len_a)
    );

    expr_nest_checker #(.MAX_DEPTH(2), .MULTI_DIGIT(0), .LEN_W(3)) dut_b (
        .clk(clk), .clr(clr), .in(in), .in_valid(in_valid),
        .out(out_b), .err(err_b), .err_code(code_b), .depth(depth_b), .len(len_b)
    );

    typedef struct {
        bit out;
        bit err;
        int code;
        int depth;
        int len;
    } res_t;

    typedef struct {
        string s;
        bit    out;
        bit    err;
        int    code;
        int    depth;
        int    len;
    } vec_t;

    vec_t tbl[$];

    function automatic bit is_dig(input logic [7:0] c);
        return c >= "0" && c <= "9";
    endfunction

    function automatic bit is_op(input logic [7:0] c);
        return c == "+" || c == "-" || c == "*" || c == "/";
    endfunction

    // Legality judged from the previous legal character and the running bracket count.
    function automatic res_t model(input logic [7:0] h[$], input int maxd, input int md, input int lenw);
        res_t r;
        logic [7:0] prev = 8'h00;
        int d = 0;
        bit e = 0;
        int code = 0;
        bit after_operand;
        foreach (h[i]) begin
            logic [7:0] c = h[i];
            if (!e) begin
                after_operand = is_dig(prev) || prev == ")";
                if (is_dig(c)) begin
                    if (after_operand && !(is_dig(prev) && md != 0)) begin e = 1; code = 1; end
                end else if (is_op(c)) begin
                    if (!after_operand) begin e = 1; code = 1; end
                end else if (c == "(") begin
                    if (after_operand) begin e = 1; code = 1; end
                    else if (d == maxd) begin e = 1; code = 2; end
                    else d++;
                end else if (c == ")") begin
                    if (!after_operand) begin e = 1; code = 1; end
                    else if (d == 0) begin e = 1; code = 3; end
                    else d--;
                end else begin
                    e = 1; code = 1;
                end
                if (!e) prev = c;
            end
        end
        r.err   = e;
        r.code  = code;
        r.depth = d;
        r.out   = !e && (is_dig(prev) || prev == ")") && d == 0;
        r.len   = (h.size() > (1 << lenw) - 1) ? (1 << lenw) - 1 : h.size();
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic check_model(input string tag);
        res_t ra, rb;
        ra = model(hist, 8, 1, 8);
        rb = model(hist, 2, 0, 3);
        chk({tag, " a.out"},   32'(out_a),   32'(ra.out));
        chk({tag, " a.err"},   32'(err_a),   32'(ra.err));
        chk({tag, " a.code"},  32'(code_a),  32'(ra.code));
        chk({tag, " a.depth"}, 32'(depth_a), 32'(ra.depth));
        chk({tag, " a.len"},   32'(len_a),   32'(ra.len));
        chk({tag, " b.out"},   32'(out_b),   32'(rb.out));
        chk({tag, " b.err"},   32'(err_b),   32'(rb.err));
        chk({tag, " b.code"},  32'(code_b),  32'(rb.code));
        chk({tag, " b.depth"}, 32'(depth_b), 32'(rb.depth));
        chk({tag, " b.len"},   32'(len_b),   32'(rb.len));
    endtask

    task automatic push(input bit v, input logic [7:0] c);
        in       = c;
        in_valid = v;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (v) hist.push_back(c);
    endtask

    task automatic do_reset();
        clr = 1'b1;
        #2;
        clr = 1'b0;
        hist.delete();
    endtask

    task automatic push_str(input string s);
        for (int i = 0; i < s.len(); i++) push(1'b1, s[i]);
    endtask

    task automatic add(input string s, input bit o, input bit e, input int c, input int d, input int l);
        vec_t v;
        v.s = s; v.out = o; v.err = e; v.code = c; v.depth = d; v.len = l;
        tbl.push_back(v);
    endtask

    initial begin
        string seq;
        int    exp_seq[5];
        clr      = 1'b1;
        in       = 8'h00;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst out",   32'(out_a),   0);
        chk("rst err",   32'(err_a),   0);
        chk("rst code",  32'(code_a),  0);
        chk("rst depth", 32'(depth_a), 0);
        chk("rst len",   32'(len_a),   0);
        clr = 1'b0;
        hist.delete();

        add("1+2*3",              1, 0, 0, 0, 5);
        add("12+(34)",            1, 0, 0, 0, 7);
        add("(1+2",               0, 0, 0, 1, 4);
        add("1)",                 0, 1, 3, 0, 2);
        add("1)+2",               0, 1, 3, 0, 4);
        add("()",                 0, 1, 1, 1, 2);
        add("",                   0, 0, 0, 0, 0);
        add("((1))",              1, 0, 0, 0, 5);
        add("1 +2",               0, 1, 1, 0, 4);
        add("1++",                0, 1, 1, 0, 3);
        add("(1)2",               0, 1, 1, 0, 4);
        add("((((((((1))))))))",  1, 0, 0, 0, 17);
        add("(((((((((",          0, 1, 2, 8, 9);
        add("a",                  0, 1, 1, 0, 1);
        add("+",                  0, 1, 1, 0, 1);
        add("9/(8-7)*6",          1, 0, 0, 0, 9);

        foreach (tbl[k]) begin
            do_reset();
            push_str(tbl[k].s);
            chk({"tbl '", tbl[k].s, "' out"},   32'(out_a),   32'(tbl[k].out));
            chk({"tbl '", tbl[k].s, "' err"},   32'(err_a),   32'(tbl[k].err));
            chk({"tbl '", tbl[k].s, "' code"},  32'(code_a),  32'(tbl[k].code));
            chk({"tbl '", tbl[k].s, "' depth"}, 32'(depth_a), 32'(tbl[k].depth));
            chk({"tbl '", tbl[k].s, "' len"},   32'(len_a),   32'(tbl[k].len));
        end

        // per-character out sequence for "1+2*3"
        do_reset();
        seq = "1+2*3";
        exp_seq = '{1, 0, 1, 0, 1};
        for (int i = 0; i < 5; i++) begin
            push(1'b1, seq[i]);
            chk($sformatf("seq out[%0d]", i), 32'(out_a), 32'(exp_seq[i]));
        end

        // nesting depth peaks at 1 inside "12+(34)"
        do_reset();
        push_str("12+(");
        chk("peak depth", 32'(depth_a), 1);
        push_str("34)");
        chk("close out", 32'(out_a), 1);

        // small-depth instance: overflow on third '('
        do_reset();
        push_str("((");
        chk("b depth2", 32'(depth_b), 2);
        chk("b no err", 32'(err_b), 0);
        push(1'b1, "(");
        chk("b ovf err",   32'(err_b),   1);
        chk("b ovf code",  32'(code_b),  2);
        chk("b ovf depth", 32'(depth_b), 2);

        // single-digit instance rejects "12"
        do_reset();
        push(1'b1, "1");
        chk("b 1 out", 32'(out_b), 1);
        push(1'b1, "2");
        chk("b 12 err",  32'(err_b),  1);
        chk("b 12 code", 32'(code_b), 1);

        // error is sticky while len keeps counting
        do_reset();
        push_str("1)+2");
        chk("unf code", 32'(code_a), 3);
        chk("unf err",  32'(err_a),  1);
        chk("unf out",  32'(out_a),  0);
        chk("unf len",  32'(len_a),  4);

        // gapped strobes leave state untouched
        do_reset();
        seq = "(1+2";
        for (int i = 0; i < 4; i++) begin
            push(1'b1, seq[i]);
            for (int g = 0; g < 3; g++) begin
                push(1'b0, "9");
                check_model($sformatf("gap c%0d g%0d", i, g));
            end
        end
        chk("gap out",   32'(out_a),   0);
        chk("gap depth", 32'(depth_a), 1);
        push(1'b1, ")");
        chk("gap close out", 32'(out_a), 1);

        // asynchronous clear between edges
        do_reset();
        push_str("(1+");
        #3;
        clr = 1'b1;
        #1;
        chk("aclr out",   32'(out_a),   0);
        chk("aclr depth", 32'(depth_a), 0);
        chk("aclr len",   32'(len_a),   0);
        chk("aclr err",   32'(err_a),   0);
        #1;
        clr = 1'b0;
        hist.delete();
        push(1'b1, "7");
        chk("aclr 7 out", 32'(out_a), 1);

        // len saturation on the narrow counter
        do_reset();
        push_str("1+2+3+4+5+6");
        chk("b len sat", 32'(len_b), 7);
        chk("a len",     32'(len_a), 11);

        // random streams against the reference model
        for (int r = 0; r < 200; r++) begin
            int n;
            do_reset();
            n = $urandom_range(1, 30);
            for (int i = 0; i < n; i++) begin
                int p;
                logic [7:0] c;
                p = $urandom_range(0, 99);
                if (p < 40)      c = 8'("0") + 8'($urandom_range(0, 9));
                else if (p < 60) begin
                    case ($urandom_range(0, 3))
                        0: c = "+";
                        1: c = "-";
                        2: c = "*";
                        default: c = "/";
                    endcase
                end
                else if (p < 78) c = "(";
                else if (p < 95) c = ")";
                else if (p < 97) c = " ";
                else             c = 8'($urandom_range(0, 255));
                push($urandom_range(0, 4) != 0, c);
                check_model($sformatf("rnd %0d/%0d", r, i));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/expr_nest_checker.md
Name: expr_nest_checker

Overview:
Streaming syntax checker for ASCII arithmetic expressions. It is the parametrised successor to the single-digit infix recogniser. It accepts one character per strobe and supports:
- optional multi-digit operands
- the four operators + - * /
- nested parentheses up to MAX_DEPTH
- a sticky error with a cause code

It sits between the UART/char source and the evaluator. `out` tells downstream whether the prefix received so far is a complete, balanced expression.

Parameters:
- MAX_DEPTH, 8, maximum parenthesis nesting depth (>=1).
- MULTI_DIGIT, 1, 1 = consecutive digits form one operand; 0 = a digit directly after a digit is a syntax error.
- LEN_W, 8, width of the accepted-character counter (saturating).

Ports:
- clk  input  1  clock, rising edge.
- clr  input  1  reset, asynchronous, active-high.
- in  input  8  ASCII character.
- in_valid  input  1  `in` is sampled on a rising clk edge only when in_valid=1.
- out  output  1  1 = accepted prefix is a complete expression with depth 0 and no error.
- err  output  1  sticky error flag.
- err_code  output  2  0 none, 1 syntax/illegal char, 2 depth overflow, 3 unmatched ')'.
- depth  output  $clog2(MAX_DEPTH+1)  current open-parenthesis count.
- len  output  LEN_W  number of characters accepted since reset, saturating at all-ones.

Behaviour:
- Character classes:
  - DIG: "0".."9"
  - OP: "+" "-" "*" "/"
  - LP: "("
  - RP: ")"
  - BAD: anything else, including space.
- States (registered): S_EXP (expect operand), S_NUM (inside operand), S_CLS (after ')'), S_ERR.
- Reset (clr=1, async): state=S_EXP, depth=0, len=0, err=0, err_code=0, out=0. clr dominates in_valid.
- in_valid=0: all registers hold.
- Transitions on an edge with in_valid=1:
  - S_EXP: DIG -> S_NUM. LP with depth<MAX_DEPTH -> depth+1, stay S_EXP. LP with depth==MAX_DEPTH -> S_ERR, code 2. OP/RP/BAD -> S_ERR, code 1.
  - S_NUM: DIG -> S_NUM if MULTI_DIGIT=1, else S_ERR code 1. OP -> S_EXP. RP with depth>0 -> depth-1, S_CLS. RP with depth==0 -> S_ERR code 3. LP/BAD -> S_ERR code 1.
  - S_CLS: OP -> S_EXP. RP with depth>0 -> depth-1, stay S_CLS. RP with depth==0 -> S_ERR code 3. DIG/LP/BAD -> S_ERR code 1.
  - S_ERR: absorbing until clr. depth and err_code freeze; len keeps counting.
- err = (state==S_ERR). err_code is written only on the transition into S_ERR and never overwritten afterwards.
- out (Moore) = (state==S_NUM || state==S_CLS) && depth==0. It reflects every character accepted up to and including the last edge, i.e. one-cycle latency from the character strobe.
- len increments on every accepted character, including ones in S_ERR, and saturates at 2^LEN_W-1 with no wrap.
- depth never wraps: overflow and underflow are converted to errors before the arithmetic.
- Empty expression ("()" or no input) -> out=0. "()" gives a syntax error on ')'.
- Unbalanced-but-valid prefix such as "(1+2" -> out=0, err=0. This is not an error; closing can still follow.

Decomposition:
- Shared package expr_pkg holds:
  - the state encoding constants S_EXP/S_NUM/S_CLS/S_ERR
  - the char-class constants DIG/OP/LP/RP/BAD
  - the err_code constants ERR_NONE/ERR_SYN/ERR_OVF/ERR_UNF
- One natural sub-module: expr_char_class, a purely combinational 8-bit ASCII -> 3-bit class decoder, reused by the evaluator.
- The FSM, depth counter and len counter stay in the top module.

Test Plan:
- "1+2*3" on consecutive cycles -> out sequence 1,0,1,0,1; err=0; len=5; depth=0.
- MULTI_DIGIT=1: "12+(34)" -> out=1 after the final ')', depth peaks at 1. With MULTI_DIGIT=0, "12" -> err=1, err_code=1 after the 2nd char.
- MAX_DEPTH=2: "(((" -> depth=2 after the 2nd '('; 3rd '(' -> err=1, err_code=2, depth stays 2.
- "1)" -> err_code=3. Subsequent "+2" keeps err=1, code=3, out=0, and len counts to 4.
- "(1+2" with in_valid gapped to 0 for 3 cycles between chars -> no state change during gaps; out=0, depth=1. Then ")" -> out=1.
- Assert clr mid-stream after "(1+" asynchronously, between edges -> immediately out=0, depth=0, len=0, err=0. Then "7" -> out=1.
